// File: rtl/router_pkg.sv
// router_pkg: shared widths, channel/state enums and header field positions for the router drain path
package router_pkg;
  localparam int DATA_W   = 8;
  localparam int LEN_W    = 6;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  typedef enum logic [1:0] {CH0, CH1, CH2} ch_e;
  typedef enum logic [1:0] {IDLE, HEAD, BODY} st_e;
  function automatic ch_e ch_next(input ch_e c);
    return (c == CH2) ? CH0 : ch_e'(c + 2'd1);
  endfunction
endpackage

// File: rtl/router_skid_buf.sv
// router_skid_buf: 2-entry skid buffer; count is exported so the arbiter can budget FIFO reads
module router_skid_buf #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;
  assign valid = cnt_q != 2'd0;
  assign head  = e0_q;
  assign count = cnt_q;
  always_comb begin
    pop   = valid & ready;
    e0_d  = pop ? e1_q : e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) e0_d = push_data;
    else if (push) e1_d = push_data;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
      assert (!(push && cnt_q == 2'd2 && !pop));
    end
  end
endmodule

// File: rtl/router_drain_arbiter.sv
// router_drain_arbiter: round-robin drain of the router's three output FIFOs into one tagged byte stream.
// Defining ARB_STATS_EN adds per-channel completed-packet counters pkt_cnt0..2.
module router_drain_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vld_out0,
  input  logic              vld_out1,
  input  logic              vld_out2,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic [DATA_W-1:0] data_out2,
  output logic              read_en0,
  output logic              read_en1,
  output logic              read_en2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        m_chan,
  output logic              m_sop,
  output logic              m_last,
  output logic              pkt_abort
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] pkt_cnt0,
  output logic [STAT_W-1:0] pkt_cnt1,
  output logic [STAT_W-1:0] pkt_cnt2
`endif
);
  localparam int PW = DATA_W + 4;
  st_e               state_q, state_d;
  ch_e               gnt_q, gnt_d, ptr_q, ptr_d, rd_chan_q, c1, c2, pick;
  logic [LEN_W:0]    rem_q, rem_d, rem_eff;
  logic              rd_q, rd_d, rd_sop_q, rd_sop_d, rd_last_q, rd_last_d, abort_q, abort_d;
  logic              gv, credit, pop;
  logic [2:0]        vld, occ;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] din;
  logic [PW-1:0]     head;
  assign vld = {vld_out2, vld_out1, vld_out0};
  assign din = (rd_chan_q == CH0) ? data_out0 : (rd_chan_q == CH1) ? data_out1 : data_out2;
  assign pop = m_valid & m_ready;
  // A byte read now lands one cycle later, so budget skid space after this cycle's pop.
  assign occ    = {1'b0, cnt} + {2'b0, rd_q} - {2'b0, pop};
  assign credit = occ < 3'd2;
  assign gv     = vld[gnt_q];
  assign c1     = ch_next(ptr_q);
  assign c2     = ch_next(c1);
  assign pick   = vld[ptr_q] ? ptr_q : vld[c1] ? c1 : c2;
  // The header arrives the cycle after its read; its length is used directly so reads stay back-to-back.
  assign rem_eff = rd_sop_q ? (LEN_W+1)'(din[LEN_MSB:LEN_LSB]) + (LEN_W+1)'(1) : rem_q;
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    rem_d     = rem_eff;
    rd_d      = 1'b0;
    rd_sop_d  = 1'b0;
    rd_last_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: if (|vld) begin
        gnt_d   = pick;
        state_d = HEAD;
      end
      HEAD, BODY: if (!gv) begin
        abort_d = 1'b1;
        state_d = IDLE;
        ptr_d   = ch_next(gnt_q);
      end else if (credit) begin
        rd_d      = 1'b1;
        rd_sop_d  = state_q == HEAD;
        rd_last_d = state_q == BODY && rem_eff == (LEN_W+1)'(1);
        rem_d     = state_q == BODY ? rem_eff - (LEN_W+1)'(1) : rem_eff;
        state_d   = rd_last_d ? IDLE : BODY;
        ptr_d     = rd_last_d ? ch_next(gnt_q) : ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign read_en0  = rd_d && gnt_q == CH0;
  assign read_en1  = rd_d && gnt_q == CH1;
  assign read_en2  = rd_d && gnt_q == CH2;
  assign pkt_abort = abort_q;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= CH0;
      ptr_q     <= CH0;
      rem_q     <= '0;
      rd_q      <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_chan_q <= CH0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      rd_q      <= rd_d;
      rd_sop_q  <= rd_sop_d;
      rd_last_q <= rd_last_d;
      rd_chan_q <= gnt_q;
      abort_q   <= abort_d;
      assert (!(rd_d && state_q == BODY && rem_eff == '0));
    end
  end
  router_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rd_q),
    .push_data ({din, rd_chan_q, rd_sop_q, rd_last_q}),
    .ready     (m_ready),
    .valid     (m_valid),
    .head      (head),
    .count     (cnt)
  );
  assign {m_data, m_chan, m_sop, m_last} = head;
`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] pc_q [3];
  logic [STAT_W-1:0] pc_d [3];
  always_comb begin
    for (int i = 0; i < 3; i++) pc_d[i] = pc_q[i] + STAT_W'(pop && m_last && m_chan == 2'(i));
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) pc_q[i] <= rstn ? pc_d[i] : '0;
  end
  assign pkt_cnt0 = pc_q[0];
  assign pkt_cnt1 = pc_q[1];
  assign pkt_cnt2 = pc_q[2];
`endif
endmodule

// File: tb/tb_router_drain_arbiter.sv
// tb_router_drain_arbiter: directed scenarios against a router FIFO model and an accepted-beat scoreboard
`timescale 1ns/1ps
module tb_router_drain_arbiter;
  typedef struct packed {logic [7:0] d; logic [1:0] c; logic s; logic l;} beat_t;
  logic clk = 1'b0, rstn = 1'b0, rdy = 1'b0, tog = 1'b0, phase = 1'b0;
  logic m_ready;
  logic vld_out0, vld_out1, vld_out2;
  logic [7:0] data_out0, data_out1, data_out2;
  logic read_en0, read_en1, read_en2;
  logic [7:0] m_data;
  logic m_valid, m_sop, m_last, pkt_abort;
  logic [1:0] m_chan;
`ifdef ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1, pkt_cnt2;
`endif
  logic [7:0] fq [3][$];
  logic [7:0] dq [3];
  logic [2:0] ne = 3'b000;
  beat_t got[$];
  beat_t exp[$];
  int tests = 0, fails = 0, cyc = 0, n_abort = 0, n_rd = 0, n_acc = 0;
  int rd_cnt [3];
  int rd_first [3];
  int rd_last [3];
  wire [2:0] re = {read_en2, read_en1, read_en0};
  assign {vld_out2, vld_out1, vld_out0} = ne;
  assign data_out0 = dq[0];
  assign data_out1 = dq[1];
  assign data_out2 = dq[2];
  assign m_ready = tog ? phase : rdy;
  always #5 clk = ~clk;
  router_drain_arbiter dut (
    .clk(clk), .rstn(rstn),
    .vld_out0(vld_out0), .vld_out1(vld_out1), .vld_out2(vld_out2),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
    .read_en0(read_en0), .read_en1(read_en1), .read_en2(read_en2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan),
    .m_sop(m_sop), .m_last(m_last), .pkt_abort(pkt_abort)
`ifdef ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2)
`endif
  );
  // Router FIFO model: one-cycle read latency, non-empty flag follows the pop
  always @(posedge clk) begin
    phase <= ~phase;
    for (int i = 0; i < 3; i++) begin
      if (re[i] && fq[i].size() > 0) dq[i] <= fq[i].pop_front();
      ne[i] <= fq[i].size() > 0;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (m_valid && m_ready) begin
        got.push_back({m_data, m_chan, m_sop, m_last});
        n_acc++;
      end
      if (pkt_abort) n_abort++;
      for (int i = 0; i < 3; i++) if (re[i]) begin
        if (rd_cnt[i] == 0) rd_first[i] = cyc;
        rd_last[i] = cyc;
        rd_cnt[i]++;
      end
      n_rd += $countones(re);
      if ((re & ~ne) != 3'b000 || $countones(re) > 1) begin
        fails++;
        $display("FAIL read_strobe: read_en=%b vld_out=%b, required one-hot subset of vld_out", re, ne);
      end
      if (n_rd - n_acc > 2) begin
        fails++;
        $display("FAIL in_flight: %0d bytes read but unaccepted, required <= 2", n_rd - n_acc);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_obs();
    got.delete();
    exp.delete();
    n_abort = 0;
    n_rd = 0;
    n_acc = 0;
    for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    rdy = 1'b0;
    tog = 1'b0;
    for (int i = 0; i < 3; i++) fq[i].delete();
    tick(2);
    rstn = 1'b1;
    clear_obs();
  endtask
  // Packet: header {len,addr=ch}, payload base+i, xor parity; only the first keep bytes enter the FIFO
  task automatic load_pkt(input int ch, input int len, input int keep, input logic [7:0] base);
    logic [7:0] b, par;
    par = 8'h00;
    for (int i = 0; i < len + 2 && i < keep; i++) begin
      b = (i == 0) ? {6'(len), 2'(ch)} : (i == len + 1) ? par : base + 8'(i);
      par ^= b;
      fq[ch].push_back(b);
      exp.push_back({b, 2'(ch), 1'(i == 0), 1'(i == len + 1)});
    end
  endtask
  task automatic wait_beats(input int n, output bit ok);
    int t = 0;
    while (got.size() < n && t < 2000) begin
      tick();
      t++;
    end
    ok = got.size() >= n;
    tick(4);
  endtask
  task automatic test_reset();
    do_reset();
    tests++;
    if ({m_valid, m_sop, m_last, pkt_abort, m_chan, m_data} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b sop=%b last=%b abort=%b chan=%0d data=%h, required all 0",
               m_valid, m_sop, m_last, pkt_abort, m_chan, m_data);
    end
    tests++;
    if (re !== 3'b000) begin
      fails++;
      $display("FAIL reset_read_en: got %b, required 000", re);
    end
  endtask
  task automatic test_single_packet();
    bit ok;
    do_reset();
    rdy = 1'b1;
    load_pkt(1, 3, 99, 8'h10);
    wait_beats(5, ok);
    tests++;
    if (!ok || got.size() != 5) begin
      fails++;
      $display("FAIL single_count: got %0d beats, required 5", got.size());
    end
    tests++;
    if (rd_cnt[1] != 5 || rd_last[1] - rd_first[1] != 4) begin
      fails++;
      $display("FAIL single_read_run: got %0d reads over %0d cycles, required 5 over 5",
               rd_cnt[1], rd_last[1] - rd_first[1] + 1);
    end
    for (int i = 0; i < exp.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL single_beat%0d: got %h, required %h", i, (i < got.size()) ? got[i] : beat_t'(0), exp[i]);
      end
    end
  endtask
  task automatic test_round_robin();
    bit ok;
    do_reset();
    rdy = 1'b1;
    load_pkt(0, 0, 99, 8'h20);
    load_pkt(1, 0, 99, 8'h30);
    load_pkt(2, 0, 99, 8'h40);
    load_pkt(0, 1, 99, 8'h50);
    wait_beats(exp.size(), ok);
    tests++;
    if (!ok || got.size() != exp.size()) begin
      fails++;
      $display("FAIL rr_count: got %0d beats, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL rr_beat%0d: got %h, required %h", i, (i < got.size()) ? got[i] : beat_t'(0), exp[i]);
      end
    end
  endtask
  task automatic test_long_backpressure();
    bit ok;
    do_reset();
    tog = 1'b1;
    load_pkt(2, 63, 99, 8'h80);
    wait_beats(65, ok);
    tog = 1'b0;
    tick(4);
    tests++;
    if (!ok || got.size() != 65) begin
      fails++;
      $display("FAIL long_count: got %0d beats, required 65", got.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL long_beat%0d: got %h, required %h", i, (i < got.size()) ? got[i] : beat_t'(0), exp[i]);
      end
    end
  endtask
  task automatic test_abort();
    bit ok;
    int t = 0;
    do_reset();
    rdy = 1'b1;
    load_pkt(2, 10, 3, 8'hA0);
    while (rd_cnt[2] == 0 && t < 100) begin
      tick();
      t++;
    end
    load_pkt(0, 1, 99, 8'hB0);
    load_pkt(1, 0, 99, 8'hC0);
    wait_beats(exp.size(), ok);
    tests++;
    if (n_abort != 1) begin
      fails++;
      $display("FAIL abort_pulses: got %0d, required 1", n_abort);
    end
    tests++;
    if (rd_cnt[2] != 3) begin
      fails++;
      $display("FAIL abort_reads: got %0d reads on ch2, required 3", rd_cnt[2]);
    end
    tests++;
    if (!ok || got.size() != exp.size()) begin
      fails++;
      $display("FAIL abort_count: got %0d beats, required %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL abort_beat%0d: got %h, required %h", i, (i < got.size()) ? got[i] : beat_t'(0), exp[i]);
      end
    end
  endtask
  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    load_pkt(1, 20, 99, 8'h60);
    tick(8);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) fq[i].delete();
    tick();
    rstn = 1'b1;
    clear_obs();
    tests++;
    if ({m_valid, m_sop, m_last, pkt_abort, m_chan, m_data, re} !== 17'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got valid=%b sop=%b last=%b abort=%b chan=%0d data=%h rd=%b, required all 0",
               m_valid, m_sop, m_last, pkt_abort, m_chan, m_data, re);
    end
    rdy = 1'b1;
    load_pkt(0, 2, 99, 8'h70);
    wait_beats(4, ok);
    tests++;
    if (!ok || got.size() != 4) begin
      fails++;
      $display("FAIL midreset_count: got %0d beats, required 4", got.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL midreset_beat%0d: got %h, required %h", i, (i < got.size()) ? got[i] : beat_t'(0), exp[i]);
      end
    end
  endtask
`ifdef ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    do_reset();
    rdy = 1'b1;
    load_pkt(1, 2, 99, 8'h11);
    wait_beats(exp.size(), ok);
    load_pkt(1, 0, 99, 8'h22);
    wait_beats(exp.size(), ok);
    load_pkt(1, 5, 2, 8'h33);
    wait_beats(exp.size(), ok);
    load_pkt(1, 1, 99, 8'h44);
    wait_beats(exp.size(), ok);
    tests++;
    if (!ok || pkt_cnt1 !== 16'd3) begin
      fails++;
      $display("FAIL stats_cnt1: got %0d, required 3", pkt_cnt1);
    end
    tests++;
    if (pkt_cnt0 !== 16'd0 || pkt_cnt2 !== 16'd0) begin
      fails++;
      $display("FAIL stats_cnt02: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt2);
    end
    tests++;
    if (n_abort != 1) begin
      fails++;
      $display("FAIL stats_abort: got %0d pulses, required 1", n_abort);
    end
  endtask
`endif
  initial begin
    for (int i = 0; i < 3; i++) begin
      dq[i] = 8'h00;
      rd_cnt[i] = 0;
      rd_first[i] = 0;
      rd_last[i] = 0;
    end
    test_reset();
    test_single_packet();
    test_round_robin();
    test_long_backpressure();
    test_abort();
    test_reset_mid_packet();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
